meas_ascii_fmt: RTL and testbench

Converts one signed millivolt measurement into the fixed 8-character ASCII line `±d.dddV\n` and hands it to the UART transmit stage as a packed char array plus a one-cycle update strobe. It sits directly upstream of the UART transmitter: it accepts a measurement strobe from the averaging/measurement path, converts binary to BCD with an iterative double-dabble, then waits for the transmitter to be idle before publishing.

---
 rtl/meas_ascii_fmt_if.sv | 26 ++
 rtl/meas_ascii_fmt.sv | 122 ++++++++++++
 tb/tb_meas_ascii_fmt.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/meas_ascii_fmt_if.sv
// Measurement-to-line handshake bundle between the measurement path, the
// ASCII formatter and the UART transmit stage.
`timescale 1ns/1ps
interface meas_ascii_fmt_if #(
  parameter int VALUE_W = 16,
  parameter int CHAR_NR = 8
);
  logic signed [VALUE_W-1:0] value_i;
  logic                      value_valid_i;
  logic                      tx_busy_i;
  logic [CHAR_NR*8-1:0]      char_array_o;
  logic                      char_array_update_o;
  logic                      busy_o;
  logic                      ovr_o;
  logic                      drop_o;

  modport master (
    output value_i, value_valid_i, tx_busy_i,
    input  char_array_o, char_array_update_o, busy_o, ovr_o, drop_o
  );

  modport slave (
    input  value_i, value_valid_i, tx_busy_i,
    output char_array_o, char_array_update_o, busy_o, ovr_o, drop_o
  );
endinterface

// File: rtl/meas_ascii_fmt.sv
// Formats a signed mV sample as the 8-char line "+d.dddV\n" using a
// 14-step iterative double-dabble, then publishes once the UART is idle.
`timescale 1ns/1ps
module meas_ascii_fmt #(
  parameter int VALUE_W = 16,
  parameter int CHAR_NR = 8
) (
  input logic              clk,
  input logic              rst,
  meas_ascii_fmt_if.slave  bus
);
  localparam int MAG_W = 14;
  localparam int BCD_W = 16;
  localparam int DD_W  = BCD_W + MAG_W;
  localparam logic [3:0] LAST_ITER = 4'd13;

  typedef enum logic [1:0] {IDLE, ABS, CONV, WAIT} state_t;

  state_t                    state_reg;
  logic signed [VALUE_W-1:0] value_reg;
  logic                      sign_reg;
  logic                      ovr_flag_reg;
  logic [DD_W-1:0]           dd_reg;
  logic [3:0]                iter_reg;
  logic [CHAR_NR*8-1:0]      char_array_reg;
  logic                      update_reg;
  logic                      busy_reg;
  logic                      ovr_reg;
  logic                      drop_reg;

  // One extra bit so that the most negative input still has a representable magnitude.
  logic [VALUE_W:0]   value_ext;
  logic [VALUE_W:0]   mag_abs;
  logic               mag_over;
  logic [MAG_W-1:0]   mag_clamped;

  always_comb begin
    value_ext   = {value_reg[VALUE_W-1], value_reg};
    mag_abs     = value_reg[VALUE_W-1] ? (~value_ext + 1'b1) : value_ext;
    mag_over    = (mag_abs > (VALUE_W+1)'(9999));
    mag_clamped = mag_over ? MAG_W'(9999) : mag_abs[MAG_W-1:0];
  end

  logic [BCD_W-1:0] bcd_adj;
  logic [DD_W-1:0]  dd_shift;
  logic [7:0]       digit_ascii [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib = dd_reg[MAG_W + gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      assign digit_ascii[gi] = {4'h3, nib};
    end
  endgenerate

  assign dd_shift = {bcd_adj[BCD_W-2:0], dd_reg[MAG_W-1:0], 1'b0};

  logic [CHAR_NR*8-1:0] line_next;

  // Char 0 is transmitted first and lives in the low byte.
  always_comb begin
    line_next = {8'h0A, 8'h56, digit_ascii[0], digit_ascii[1], digit_ascii[2],
                 8'h2E, digit_ascii[3], (sign_reg ? 8'h2D : 8'h2B)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      value_reg      <= '0;
      sign_reg       <= 1'b0;
      ovr_flag_reg   <= 1'b0;
      dd_reg         <= '0;
      iter_reg       <= '0;
      char_array_reg <= {CHAR_NR{8'h20}};
      update_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      ovr_reg        <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      update_reg <= 1'b0;
      drop_reg   <= bus.value_valid_i && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (bus.value_valid_i) begin
            value_reg <= bus.value_i;
            busy_reg  <= 1'b1;
            state_reg <= ABS;
          end
        end
        ABS: begin
          sign_reg     <= value_reg[VALUE_W-1];
          ovr_flag_reg <= mag_over;
          dd_reg       <= {{BCD_W{1'b0}}, mag_clamped};
          iter_reg     <= '0;
          state_reg    <= CONV;
        end
        CONV: begin
          dd_reg   <= dd_shift;
          iter_reg <= iter_reg + 4'd1;
          if (iter_reg == LAST_ITER) state_reg <= WAIT;
        end
        WAIT: begin
          if (!bus.tx_busy_i) begin
            char_array_reg <= line_next;
            ovr_reg        <= ovr_flag_reg;
            update_reg     <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.char_array_o        = char_array_reg;
  assign bus.char_array_update_o = update_reg;
  assign bus.busy_o              = busy_reg;
  assign bus.ovr_o               = ovr_reg;
  assign bus.drop_o              = drop_reg;
endmodule

// File: tb/tb_meas_ascii_fmt.sv
// Bench for meas_ascii_fmt: vector table plus hand sequences, with a
// scoreboard of expected updates and drop pulses checked by a monitor.
`timescale 1ns/1ps
module tb_meas_ascii_fmt;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  meas_ascii_fmt_if #(.VALUE_W(16), .CHAR_NR(8)) bus();
  meas_ascii_fmt #(.VALUE_W(16), .CHAR_NR(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [63:0] SPACES = 64'h2020_2020_2020_2020;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] line; logic ovr; int cyc; } exp_t;
  typedef struct { logic signed [15:0] value; logic [63:0] line; logic ovr; } vec_t;

  exp_t upd_q[$];
  int   drop_q[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: {ovr, line} computed arithmetically from the integer value.
  function automatic logic [64:0] model(input int v);
    int m;
    logic o;
    m = (v < 0) ? -v : v;
    o = (m > 9999);
    if (o) m = 9999;
    return {o, 8'h0A, 8'h56, 8'h30 + 8'(m % 10), 8'h30 + 8'((m / 10) % 10),
            8'h30 + 8'((m / 100) % 10), 8'h2E, 8'h30 + 8'(m / 1000),
            (v < 0) ? 8'h2D : 8'h2B};
  endfunction

  always @(negedge clk) begin
    if (bus.char_array_update_o) begin
      if (upd_q.size() == 0) begin
        chk("unexpected_update", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = upd_q.pop_front();
        $display("update cycle %0d line %h ovr %0b", cyc, bus.char_array_o, bus.ovr_o);
        chk("line", bus.char_array_o, e.line);
        chk("ovr", 64'(bus.ovr_o), 64'(e.ovr));
        chk("update_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_in_update", 64'(bus.busy_o), 64'd0);
      end
    end
    if (bus.drop_o) begin
      if (drop_q.size() == 0) begin
        chk("unexpected_drop", 64'd1, 64'd0);
      end else begin
        int dc;
        dc = drop_q.pop_front();
        $display("drop cycle %0d", cyc);
        chk("drop_cycle", 64'(cyc), 64'(dc));
      end
    end
  end

  task automatic send(input logic signed [15:0] v, input logic [63:0] line,
                      input logic ovr, input int lat);
    exp_t e;
    e.line = line;
    e.ovr  = ovr;
    e.cyc  = cyc + lat;
    upd_q.push_back(e);
    bus.value_i       = v;
    bus.value_valid_i = 1'b1;
    @(negedge clk);
    bus.value_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        bad;
    logic [64:0] m;
    int          v;
    int          t;

    vecs[0]  = '{16'sd1234,   64'h0A56_3433_322E_312B, 1'b0};
    vecs[1]  = '{16'sd0,      64'h0A56_3030_302E_302B, 1'b0};
    vecs[2]  = '{-16'sd5,     64'h0A56_3530_302E_302D, 1'b0};
    vecs[3]  = '{16'sd12000,  64'h0A56_3939_392E_392B, 1'b1};
    vecs[4]  = '{-16'sd32768, 64'h0A56_3939_392E_392D, 1'b1};
    vecs[5]  = '{16'sd9999,   64'h0A56_3939_392E_392B, 1'b0};
    vecs[6]  = '{16'sd10000,  64'h0A56_3939_392E_392B, 1'b1};
    vecs[7]  = '{-16'sd9999,  64'h0A56_3939_392E_392D, 1'b0};
    vecs[8]  = '{16'sd1,      64'h0A56_3130_302E_302B, 1'b0};
    vecs[9]  = '{-16'sd1,     64'h0A56_3130_302E_302D, 1'b0};
    vecs[10] = '{16'sd5678,   64'h0A56_3837_362E_352B, 1'b0};
    vecs[11] = '{16'sd32767,  64'h0A56_3939_392E_392B, 1'b1};

    rst = 1'b1;
    bus.value_i = '0;
    bus.value_valid_i = 1'b0;
    bus.tx_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.char_array_update_o || bus.drop_o || bus.busy_o) bad = 1'b1;
    end
    chk("reset_line", bus.char_array_o, SPACES);
    chk("reset_strobes", 64'(bad), 64'd0);
    chk("reset_ovr", 64'(bus.ovr_o), 64'd0);

    // Back-to-back: each new valid lands in the previous update cycle.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].value, vecs[i].line, vecs[i].ovr, 17);
      repeat (16) @(negedge clk);
    end

    for (int k = 0; k < 6; k++) begin
      v = int'($urandom_range(40000)) - 20000;
      m = model(v);
      send(16'(v), m[63:0], m[64], 17);
      repeat (16) @(negedge clk);
    end

    // Sample arriving mid-conversion is dropped; new valid in update cycle accepted.
    send(16'sd1234, 64'h0A56_3433_322E_312B, 1'b0, 17);
    repeat (4) @(negedge clk);
    bus.value_i = 16'sd42;
    bus.value_valid_i = 1'b1;
    drop_q.push_back(cyc + 1);
    @(negedge clk);
    bus.value_valid_i = 1'b0;
    repeat (11) @(negedge clk);
    send(16'sd777, 64'h0A56_3737_372E_302B, 1'b0, 17);
    repeat (16) @(negedge clk);

    // Transmitter busy for 100 cycles holds the line in WAIT.
    bus.tx_busy_i = 1'b1;
    send(16'sd12000, 64'h0A56_3939_392E_392B, 1'b1, 101);
    bad = 1'b0;
    for (int k = 0; k < 99; k++) begin
      if (!bus.busy_o) bad = 1'b1;
      @(negedge clk);
    end
    if (!bus.busy_o) bad = 1'b1;
    bus.tx_busy_i = 1'b0;
    chk("busy_during_wait", 64'(bad), 64'd0);
    repeat (6) @(negedge clk);

    // Reset during CONV aborts with no update.
    bus.value_i = 16'sd555;
    bus.value_valid_i = 1'b1;
    @(negedge clk);
    bus.value_valid_i = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_line", bus.char_array_o, SPACES);
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    chk("abort_ovr", 64'(bus.ovr_o), 64'd0);
    chk("abort_update", 64'(bus.char_array_update_o), 64'd0);
    repeat (30) @(negedge clk);
    send(16'sd777, 64'h0A56_3737_372E_302B, 1'b0, 17);
    repeat (16) @(negedge clk);

    t = 0;
    while (upd_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("pending_updates", 64'(upd_q.size()), 64'd0);
    chk("pending_drops", 64'(drop_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
